// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue: producer end of the sprite draw queue.
// Assembles 6-byte sprite records (id, x_hi, x_lo, y_hi, y_lo, scale) from a
// byte stream into a FIFO. The head record is presented show-ahead and is
// popped by the consumer's one-cycle dequeue pulse. fb_resetting flushes all
// state, so every frame starts with an empty queue.
//
// Ports:
//   clock, fb_resetting           clock; asynchronous active-high reset/flush
//   in_valid/in_first/in_data     command byte stream; in_first restarts a record
//   in_ready                      byte accepted when in_valid && in_ready
//   sprite_queue_dequeue          pop request from the distributor
//   sprite_queue_is_empty         no valid head record (registered)
//   sprite_queue_sprite_*         head record fields (registered)
//   queue_count                   number of stored records
// Optional (macro SPRITE_QUEUE_STATS_EN):
//   stat_high_water               maximum queue_count since reset
//   stat_drops                    saturating count of cycles with a refused byte
module sprite_cmd_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     fb_resetting,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     sprite_queue_dequeue,
  output logic                     sprite_queue_is_empty,
  output logic [7:0]               sprite_queue_sprite_id,
  output logic [15:0]              sprite_queue_sprite_x,
  output logic [15:0]              sprite_queue_sprite_y,
  output logic [7:0]               sprite_queue_sprite_scale,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef SPRITE_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   stat_high_water,
  output logic [15:0]              stat_drops
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } rec_t;

  typedef enum logic [2:0] {
    IDX0 = 3'd0,
    IDX1 = 3'd1,
    IDX2 = 3'd2,
    IDX3 = 3'd3,
    IDX4 = 3'd4,
    IDX5 = 3'd5
  } idx_e;

  idx_e            idx_q, idx_d, eff_idx;
  logic            accept, push, pop;
  logic [7:0]      part_id, part_x_hi, part_x_lo, part_y_hi, part_y_lo;
  rec_t            new_rec;
  rec_t            mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  rec_t            head_q, head_d;
  logic            empty_q;

  // Byte handshake; the registered count gates acceptance, no pop look-ahead.
  assign in_ready = !fb_resetting && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign eff_idx  = in_first ? IDX0 : idx_q;
  assign new_rec  = {part_id, part_x_hi, part_x_lo, part_y_hi, part_y_lo, in_data};
  assign pop      = sprite_queue_dequeue && (count_q != '0);

  // Assembler byte-index register.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) idx_q <= IDX0;
    else              idx_q <= idx_d;
  end

  // Assembler next index; the byte at index 5 completes and pushes the record.
  always_comb begin
    idx_d = idx_q;
    push  = 1'b0;
    if (accept) begin
      case (eff_idx)
        IDX0:    idx_d = IDX1;
        IDX1:    idx_d = IDX2;
        IDX2:    idx_d = IDX3;
        IDX3:    idx_d = IDX4;
        IDX4:    idx_d = IDX5;
        IDX5: begin
          idx_d = IDX0;
          push  = 1'b1;
        end
        default: idx_d = IDX0;
      endcase
    end
  end

  // Partial record bytes; the scale byte goes straight into the FIFO.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      part_id   <= '0;
      part_x_hi <= '0;
      part_x_lo <= '0;
      part_y_hi <= '0;
      part_y_lo <= '0;
    end else if (accept) begin
      case (eff_idx)
        IDX0:    part_id   <= in_data;
        IDX1:    part_x_hi <= in_data;
        IDX2:    part_x_lo <= in_data;
        IDX3:    part_y_hi <= in_data;
        IDX4:    part_y_lo <= in_data;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= new_rec;
  end

  // Pointer/count/head next state. The head bypasses the pushed record when it
  // lands exactly at the new read pointer (push into empty, or push+pop at 1).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = '0;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = new_rec;
      else                                head_d = mem[rd_ptr_d];
    end
  end

  // FIFO control and registered head.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= (count_d == '0);
    end
  end

  assign queue_count               = count_q;
  assign sprite_queue_is_empty     = empty_q;
  assign sprite_queue_sprite_id    = head_q.id;
  assign sprite_queue_sprite_x     = head_q.x;
  assign sprite_queue_sprite_y     = head_q.y;
  assign sprite_queue_sprite_scale = head_q.scale;

`ifdef SPRITE_QUEUE_STATS_EN
  // High-water mark and saturating refused-byte counter.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      stat_high_water <= '0;
      stat_drops      <= '0;
    end else begin
      if (count_d > stat_high_water) stat_high_water <= count_d;
      if (in_valid && !in_ready && (stat_drops != 16'hFFFF))
        stat_drops <= stat_drops + 16'd1;
    end
  end
`endif

endmodule
